fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, PC of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 branch_target_valid  input  1  redirect request from execute.
REQ-005 branch_target  input  64  redirect PC from execute.
REQ-006 branch_target_retry  output  1  redirect backpressure to execute; tied 0, so a redirect is accepted every cycle.
REQ-007 imem_req_valid  output  1  instruction memory read request.
REQ-008 imem_req_addr  output  64  read address; bits [1:0] always 0.
REQ-009 imem_req_retry  input  1  memory not accepting; the request is taken only when imem_req_valid && !imem_req_retry.
REQ-010 imem_resp_valid  input  1  read data returning, at least 1 cycle after acceptance.
REQ-011 imem_resp_data  input  32  instruction word.
REQ-012 insn_valid  output  1  instruction available to decode.
REQ-013 insn  output  32  instruction to decode.
REQ-014 pc  output  64  PC of insn.
REQ-015 insn_retry  input  1  decode stall; transfer occurs only when insn_valid && !insn_retry.

Function
REQ-016 Fetch PC register fpc (64b) holds the address of the next request; imem_req_addr SHALL equal fpc.
REQ-017 Output queue: 2 entries {insn, pc}, circular, 1-bit read/write pointers that wrap, count 0..2; insn_valid = (count != 0); insn/pc come from the head entry.
REQ-018 Dequeue SHALL occur on insn_valid && !insn_retry, with the head pointer advancing with wrap.
REQ-019 Request FSM states are IDLE (nothing outstanding), WAIT (live request outstanding) and STALE (outstanding response to be discarded); at most 1 request is outstanding.
REQ-020 In IDLE, imem_req_valid SHALL be 1 iff count + 0 < 2 after this cycle's dequeue is applied (space for the response) and branch_target_valid = 0.
REQ-021 On acceptance in IDLE, the FSM goes to WAIT and fpc advances to fpc + 4 (64-bit wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0).
REQ-022 In WAIT, on imem_resp_valid: enqueue {imem_resp_data, PC of the request} and go to IDLE; a request may be issued again the following cycle.
REQ-023 In STALE, on imem_resp_valid: discard the data (no enqueue) and go to IDLE.
REQ-024 In WAIT and STALE, imem_req_valid SHALL be 0.
REQ-025 Redirect (branch_target_valid = 1) SHALL do all of the following:
- fpc <= {branch_target[63:2], 2'b00};
- flush the queue (count <= 0; pointers equal);
- WAIT -> STALE;
- STALE stays STALE;
- IDLE stays IDLE with no request that cycle.
REQ-026 A redirect in the same cycle as imem_resp_valid in WAIT SHALL drop the response and go to IDLE.
REQ-027 A redirect has priority over a same-cycle dequeue and enqueue; the queue is empty next cycle.
REQ-028 Simultaneous enqueue and dequeue with count = 2 is impossible by REQ-020; with count = 1 the count stays 1.
REQ-029 Redirect-to-first-request latency: the redirect cycle has no request; imem_req_valid with addr = target occurs the next cycle if IDLE and space exists.
REQ-030 Back-to-back redirects: the last one wins; each redirect flushes again.
REQ-031 Best-case throughput: 1 instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-032 While reset = 1, the block SHALL set fpc = RESET_PC, count = 0, pointers = 0 and state IDLE, and hold insn_valid = 0 and imem_req_valid = 0; a response arriving during reset is ignored.
REQ-033 Reset mid-operation SHALL abandon any outstanding request; a response arriving after reset deasserts, with no request issued since, SHALL be ignored.
REQ-034 The first request SHALL issue in the first cycle after reset deasserts, with imem_req_addr = RESET_PC.

Verification
REQ-035 Reset release, memory with 1-cycle latency, insn_retry = 0 -> requests at 0x0, 0x4, 0x8; decode sees pc 0x0, 0x4, 0x8 in order with matching data.
REQ-036 insn_retry held at 1 -> exactly 2 entries enqueued, imem_req_valid held 0, insn/pc stable; release insn_retry -> in-order drain, then fetch resumes at 0x8.
REQ-037 imem_req_retry = 1 for 3 cycles -> imem_req_valid and addr held constant, fpc not advanced; acceptance on the 4th cycle.
REQ-038 Redirect to 64'h1003 while in WAIT -> outstanding response (addr 0x4) dropped; next request addr 64'h1000; first pc seen is 64'h1000.
REQ-039 Redirect in the same cycle as a response and a dequeue with count = 1 -> insn_valid = 0 next cycle; no stale entry is ever delivered.
REQ-040 RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC -> second request address 64'h0.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem read, 2-entry {insn, pc} output queue,
// redirect from execute flushes the queue and discards any in-flight response.
module fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_target_valid,
    input  logic [63:0] branch_target,
    output logic        branch_target_retry,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_retry,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [63:0] pc,
    input  logic        insn_retry
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STALE
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   fpc_q, fpc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ILEN-1:0]   insn_mem_q [DEPTH];
    logic [XLEN-1:0]   pc_mem_q   [DEPTH];

    logic              deq;
    logic              enq;
    logic              accept;
    logic [1:0]        count_after_deq;
    logic              unused_bt_low;

    assign unused_bt_low = ^branch_target[1:0];

    // Request/queue control; redirect overrides everything else in the cycle.
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        req_pc_d = req_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        branch_target_retry = 1'b0;
        insn_valid          = !reset && (count_q != 2'd0);
        insn                = insn_mem_q[rd_ptr_q];
        pc                  = pc_mem_q[rd_ptr_q];
        deq                 = insn_valid && !insn_retry;
        count_after_deq     = count_q - 2'(deq);
        imem_req_valid      = !reset && (state_q == S_IDLE) &&
                              (count_after_deq < 2'd2) && !branch_target_valid;
        imem_req_addr       = fpc_q;
        accept              = imem_req_valid && !imem_req_retry;
        enq                 = (state_q == S_WAIT) && imem_resp_valid && !branch_target_valid;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_WAIT;
                    req_pc_d = fpc_q;
                    fpc_d    = fpc_q + XLEN'(4);
                end
            end
            S_WAIT: begin
                if (imem_resp_valid)          state_d = S_IDLE;
                else if (branch_target_valid) state_d = S_STALE;
            end
            S_STALE: begin
                if (imem_resp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rd_ptr_d = rd_ptr_q ^ deq;
        wr_ptr_d = wr_ptr_q ^ enq;
        count_d  = count_after_deq + 2'(enq);

        if (branch_target_valid) begin
            fpc_d    = {branch_target[XLEN-1:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fpc_q    <= RESET_PC;
            req_pc_q <= RESET_PC;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            insn_mem_q[wr_ptr_q] <= imem_resp_data;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: queue-based reference model plus a variable-latency
// memory; a second instance checks PC wrap from the top of the address space.
module tb_fetch;

    localparam int unsigned NCYC = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btv = 1'b0;
    logic [63:0] bt = 64'h0;
    logic        bt_retry;
    logic        req_v;
    logic [63:0] req_addr;
    logic        req_retry = 1'b0;
    logic        resp_v = 1'b0;
    logic [31:0] resp_d = 32'h0;
    logic        iv;
    logic [31:0] insn;
    logic [63:0] pc;
    logic        iretry = 1'b0;

    logic        bt_retry2, req_v2, iv2;
    logic [63:0] req_addr2, pc2;
    logic [31:0] insn2;
    logic        resp_v2 = 1'b0;
    logic [63:0] addr2_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch dut (
        .clk(clk), .reset(reset),
        .branch_target_valid(btv), .branch_target(bt), .branch_target_retry(bt_retry),
        .imem_req_valid(req_v), .imem_req_addr(req_addr), .imem_req_retry(req_retry),
        .imem_resp_valid(resp_v), .imem_resp_data(resp_d),
        .insn_valid(iv), .insn(insn), .pc(pc), .insn_retry(iretry)
    );

    fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .branch_target_valid(1'b0), .branch_target(64'h0), .branch_target_retry(bt_retry2),
        .imem_req_valid(req_v2), .imem_req_addr(req_addr2), .imem_req_retry(1'b0),
        .imem_resp_valid(resp_v2), .imem_resp_data(32'h0),
        .insn_valid(iv2), .insn(insn2), .pc(pc2), .insn_retry(1'b0)
    );

    // Single-cycle memory for the wrap instance; records accepted addresses.
    always @(posedge clk) begin
        resp_v2 <= !reset && req_v2;
        if (!reset && req_v2) addr2_q.push_back(req_addr2);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return 32'(a >> 2) ^ a[63:32] ^ 32'h5EED_0000;
    endfunction

    typedef struct {
        logic [31:0] insn;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    ent_t  mq  [$];
    mreq_t mem [$];

    logic [63:0] m_fpc;
    logic [63:0] m_req_pc;
    bit          m_out;
    bit          m_stale;

    initial begin
        bit          quiet, e_iv, deq, e_req, mem_acc;
        logic [63:0] acc_addr;
        int          lat;

        m_fpc    = 64'h0;
        m_req_pc = 64'h0;
        m_out    = 1'b0;
        m_stale  = 1'b0;

        for (int cyc = 0; cyc < int'(NCYC); cyc++) begin
            @(negedge clk);
            quiet     = (cyc < 30);
            reset     = (cyc < 3) || (!quiet && $urandom_range(0, 299) == 0);
            btv       = !quiet && ($urandom_range(0, 15) == 0);
            bt        = {$urandom, $urandom};
            if (cyc >= 60 && cyc < 80) bt = 64'h1003;
            iretry    = !quiet && ($urandom_range(0, 9) < 3);
            if (cyc >= 200 && cyc < 215) iretry = 1'b1;
            req_retry = !quiet && ($urandom_range(0, 3) == 0);
            if (mem.size() != 0 && mem[0].due <= cyc) begin
                resp_v = 1'b1;
                resp_d = mem_data(mem[0].addr);
            end else begin
                resp_v = 1'b0;
                resp_d = $urandom;
            end
            #1;

            if (reset) begin
                check("rst_insn_valid", 64'(iv), 64'h0);
                check("rst_req_valid", 64'(req_v), 64'h0);
                mq.delete();
                m_fpc   = 64'h0;
                m_out   = 1'b0;
                m_stale = 1'b0;
                mem_acc = 1'b0;
            end else begin
                e_iv = (mq.size() != 0);
                check("insn_valid", 64'(iv), 64'(e_iv));
                if (e_iv && iv) begin
                    check("insn", 64'(insn), 64'(mq[0].insn));
                    check("pc", pc, mq[0].pc);
                end
                check("bt_retry", 64'(bt_retry), 64'h0);
                deq   = e_iv && !iretry;
                e_req = !m_out && (mq.size() - int'(deq) < 2) && !btv;
                check("req_valid", 64'(req_v), 64'(e_req));
                if (e_req) check("req_addr", req_addr, m_fpc);

                if (deq) void'(mq.pop_front());
                if (btv) begin
                    mq.delete();
                    m_fpc = {bt[63:2], 2'b00};
                    if (m_out && resp_v) m_out = 1'b0;
                    else if (m_out)      m_stale = 1'b1;
                end else begin
                    if (m_out && resp_v) begin
                        if (!m_stale) mq.push_back('{resp_d, m_req_pc});
                        m_out = 1'b0;
                    end
                    if (e_req && !req_retry) begin
                        m_out    = 1'b1;
                        m_stale  = 1'b0;
                        m_req_pc = m_fpc;
                        m_fpc    = m_fpc + 64'd4;
                    end
                end
                mem_acc = req_v && !req_retry;
            end
            acc_addr = req_addr;
            lat      = $urandom_range(1, 3);

            @(posedge clk);
            if (resp_v) void'(mem.pop_front());
            if (mem_acc) mem.push_back('{acc_addr, cyc + lat});
        end

        check("wrap_req_count_ok", 64'(addr2_q.size() >= 2), 64'h1);
        if (addr2_q.size() >= 2) begin
            check("wrap_first_addr", addr2_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_second_addr", addr2_q[1], 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
